// File: rtl/cpu_jmp_unit.sv
// Next-PC jump unit: absolute/base/PC-relative jumps, CALL/RET through a small
// return stack, and sticky overflow/underflow flags.
module cpu_jmp_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [2:0]                 JMP_MODE,
  input  logic [WIDTH-1:0]           OFFSET,
  input  logic [WIDTH-1:0]           PC_NEXT,
  input  logic                       BASE_REG_LD,
  input  logic [WIDTH-1:0]           BASE_REG_DATA,
  input  logic                       ERR_CLR,
  output logic [WIDTH-1:0]           ADDRESS_OUT,
  output logic                       JMP_TAKEN,
  output logic [WIDTH-1:0]           BASE_ADDR_OUT,
  output logic [$clog2(DEPTH):0]     SP_OUT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [2:0] MODE_ABS   = 3'b000;
  localparam logic [2:0] MODE_BASE  = 3'b001;
  localparam logic [2:0] MODE_PCREL = 3'b010;
  localparam logic [2:0] MODE_CALLA = 3'b011;
  localparam logic [2:0] MODE_CALLB = 3'b100;
  localparam logic [2:0] MODE_RET   = 3'b101;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] base_q, base_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             full, empty;
  logic             push, pop;
  logic             ovf_set, unf_set;
  logic [SPW-1:0]   sp_minus1;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] addr;
  logic             taken;

  assign full      = (sp_q == SPW'(DEPTH));
  assign empty     = (sp_q == '0);
  assign sp_minus1 = sp_q - SPW'(1);
  assign rd_idx    = sp_minus1[AW-1:0];
  assign wr_idx    = sp_q[AW-1:0];

  // Target select and stack intent; the jump itself is purely combinational.
  always_comb begin
    addr    = PC_NEXT;
    taken   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (EN) begin
      case (JMP_MODE)
        MODE_ABS: begin
          addr  = OFFSET;
          taken = 1'b1;
        end
        MODE_BASE: begin
          addr  = base_q + OFFSET;
          taken = 1'b1;
        end
        MODE_PCREL: begin
          addr  = PC_NEXT + OFFSET;
          taken = 1'b1;
        end
        MODE_CALLA, MODE_CALLB: begin
          addr  = (JMP_MODE == MODE_CALLA) ? OFFSET : base_q + OFFSET;
          taken = 1'b1;
          if (full) ovf_set = 1'b1;
          else      push    = 1'b1;
        end
        MODE_RET: begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            addr  = stack_q[rd_idx];
            taken = 1'b1;
            pop   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    base_d = BASE_REG_LD ? BASE_REG_DATA : base_q;
    sp_d   = sp_q;
    if (push)     sp_d = sp_q + SPW'(1);
    else if (pop) sp_d = sp_minus1;
    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~ERR_CLR);
    unf_d = unf_set | (unf_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      base_q <= '0;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is unreset; entries at or above SP are never read.
  always_ff @(posedge CLK) begin
    if (!RST && push) stack_q[wr_idx] <= PC_NEXT;
  end

  assign ADDRESS_OUT   = addr;
  assign JMP_TAKEN     = taken;
  assign BASE_ADDR_OUT = base_q;
  assign SP_OUT        = sp_q;
  assign FULL          = full;
  assign EMPTY         = empty;
  assign OVF           = ovf_q;
  assign UNF           = unf_q;

endmodule

// File: tb/tb_cpu_jmp_unit.sv
// Directed bench for cpu_jmp_unit: expectations are queued with the stimulus
// and popped against the DUT outputs after each settle point.
module tb_cpu_jmp_unit;

  logic       CLK = 1'b0;
  logic       RST, EN, BASE_REG_LD, ERR_CLR;
  logic [2:0] JMP_MODE;
  logic [7:0] OFFSET, PC_NEXT, BASE_REG_DATA;
  logic [7:0] ADDRESS_OUT, BASE_ADDR_OUT;
  logic       JMP_TAKEN, FULL, EMPTY, OVF, UNF;
  logic [2:0] SP_OUT;

  cpu_jmp_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .JMP_MODE(JMP_MODE), .OFFSET(OFFSET),
    .PC_NEXT(PC_NEXT), .BASE_REG_LD(BASE_REG_LD), .BASE_REG_DATA(BASE_REG_DATA),
    .ERR_CLR(ERR_CLR), .ADDRESS_OUT(ADDRESS_OUT), .JMP_TAKEN(JMP_TAKEN),
    .BASE_ADDR_OUT(BASE_ADDR_OUT), .SP_OUT(SP_OUT), .FULL(FULL), .EMPTY(EMPTY),
    .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  typedef enum int { K_ADDR, K_TAKEN, K_BASE, K_SP, K_FULL, K_EMPTY, K_OVF, K_UNF } kind_t;
  typedef struct {
    string      tag;
    kind_t      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [7:0] observe(kind_t k);
    case (k)
      K_ADDR:  return ADDRESS_OUT;
      K_TAKEN: return {7'd0, JMP_TAKEN};
      K_BASE:  return BASE_ADDR_OUT;
      K_SP:    return {5'd0, SP_OUT};
      K_FULL:  return {7'd0, FULL};
      K_EMPTY: return {7'd0, EMPTY};
      K_OVF:   return {7'd0, OVF};
      default: return {7'd0, UNF};
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_t k, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind);
      total_cnt++;
      assert (obs === e.exp) begin
        pass_cnt++;
        $display("check %s observed=%h expected=%h ok", e.tag, obs, e.exp);
      end else begin
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; EN = 0; JMP_MODE = 3'b110; OFFSET = 0; BASE_REG_LD = 0;
    BASE_REG_DATA = 0; ERR_CLR = 0;
  endtask

  task automatic load_base(input logic [7:0] v);
    idle();
    BASE_REG_LD = 1; BASE_REG_DATA = v;
    tick();
    BASE_REG_LD = 0;
    expect_val("base_load", K_BASE, v);
    check_all();
  endtask

  task automatic jump(input logic [2:0] m, input logic [7:0] pc, input logic [7:0] off);
    idle();
    EN = 1; JMP_MODE = m; PC_NEXT = pc; OFFSET = off;
    #1;
  endtask

  logic [2:0] sweep_mode [4] = '{3'b000, 3'b001, 3'b010, 3'b110};
  logic [7:0] sweep_addr [4] = '{8'h05, 8'h45, 8'h15, 8'h10};
  logic [7:0] call_pc    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    idle();
    PC_NEXT = 8'h10;
    RST = 1;
    tick();
    expect_val("rst_sp", K_SP, 8'd0);
    expect_val("rst_empty", K_EMPTY, 8'd1);
    expect_val("rst_full", K_FULL, 8'd0);
    expect_val("rst_base", K_BASE, 8'h00);
    expect_val("rst_ovf", K_OVF, 8'd0);
    expect_val("rst_unf", K_UNF, 8'd0);
    expect_val("rst_addr", K_ADDR, 8'h10);
    expect_val("rst_taken", K_TAKEN, 8'd0);
    check_all();

    // Mode sweep
    load_base(8'h40);
    for (int i = 0; i < 4; i++) begin
      jump(sweep_mode[i], 8'h10, 8'h05);
      expect_val($sformatf("sweep_addr_m%0d", sweep_mode[i]), K_ADDR, sweep_addr[i]);
      expect_val($sformatf("sweep_taken_m%0d", sweep_mode[i]), K_TAKEN, (i == 3) ? 8'd0 : 8'd1);
      check_all();
      tick();
    end
    jump(3'b111, 8'h10, 8'h05);
    expect_val("noop7_addr", K_ADDR, 8'h10);
    expect_val("noop7_taken", K_TAKEN, 8'd0);
    check_all();
    jump(3'b000, 8'h10, 8'h05);
    EN = 0;
    #1;
    expect_val("en0_addr", K_ADDR, 8'h10);
    expect_val("en0_taken", K_TAKEN, 8'd0);
    check_all();
    tick();
    expect_val("sweep_sp", K_SP, 8'd0);
    check_all();

    // Wrap-around
    load_base(8'hF0);
    jump(3'b001, 8'h10, 8'h20);
    expect_val("wrap_addr", K_ADDR, 8'h10);
    expect_val("wrap_taken", K_TAKEN, 8'd1);
    check_all();
    tick();
    expect_val("wrap_ovf", K_OVF, 8'd0);
    expect_val("wrap_unf", K_UNF, 8'd0);
    check_all();

    // Fill the stack
    for (int i = 0; i < 4; i++) begin
      jump(3'b011, call_pc[i], 8'h80);
      expect_val($sformatf("call%0d_addr", i), K_ADDR, 8'h80);
      expect_val($sformatf("call%0d_taken", i), K_TAKEN, 8'd1);
      check_all();
      tick();
      expect_val($sformatf("call%0d_sp", i), K_SP, 8'(i + 1));
      check_all();
    end
    expect_val("fill_full", K_FULL, 8'd1);
    check_all();
    jump(3'b100, 8'h55, 8'h20);
    expect_val("ovfcall_addr", K_ADDR, 8'h10);
    expect_val("ovfcall_taken", K_TAKEN, 8'd1);
    check_all();
    tick();
    expect_val("ovfcall_ovf", K_OVF, 8'd1);
    expect_val("ovfcall_sp", K_SP, 8'd4);
    check_all();

    idle(); ERR_CLR = 1;
    tick();
    expect_val("ovf_clr", K_OVF, 8'd0);
    check_all();

    // Unwind in LIFO order
    for (int i = 3; i >= 0; i--) begin
      jump(3'b101, 8'h99, 8'h00);
      expect_val($sformatf("ret%0d_addr", i), K_ADDR, call_pc[i]);
      expect_val($sformatf("ret%0d_taken", i), K_TAKEN, 8'd1);
      check_all();
      tick();
      expect_val($sformatf("ret%0d_sp", i), K_SP, 8'(i));
      check_all();
    end
    expect_val("unwind_empty", K_EMPTY, 8'd1);
    check_all();

    // Underflow
    jump(3'b101, 8'h30, 8'h00);
    expect_val("unf_addr", K_ADDR, 8'h30);
    expect_val("unf_taken", K_TAKEN, 8'd0);
    check_all();
    tick();
    expect_val("unf_set", K_UNF, 8'd1);
    expect_val("unf_sp", K_SP, 8'd0);
    check_all();
    idle(); ERR_CLR = 1;
    tick();
    expect_val("unf_clr", K_UNF, 8'd0);
    check_all();
    jump(3'b101, 8'h30, 8'h00);
    ERR_CLR = 1;
    tick();
    expect_val("unf_set_wins", K_UNF, 8'd1);
    check_all();

    // Base load collides with base-relative jump
    load_base(8'h10);
    jump(3'b001, 8'h00, 8'h01);
    BASE_REG_LD = 1; BASE_REG_DATA = 8'h80;
    #1;
    expect_val("coll_old_base", K_ADDR, 8'h11);
    check_all();
    tick();
    BASE_REG_LD = 0;
    #1;
    expect_val("coll_new_base", K_ADDR, 8'h81);
    check_all();

    // Reset mid-operation: SP=3, OVF=1, base=0x55
    for (int i = 0; i < 5; i++) begin
      jump(3'b011, 8'h60 + 8'(i), 8'h00);
      tick();
    end
    jump(3'b101, 8'h00, 8'h00);
    BASE_REG_LD = 1; BASE_REG_DATA = 8'h55;
    tick();
    expect_val("pre_rst_sp", K_SP, 8'd3);
    expect_val("pre_rst_ovf", K_OVF, 8'd1);
    expect_val("pre_rst_base", K_BASE, 8'h55);
    check_all();
    jump(3'b011, 8'h77, 8'h20);
    RST = 1; BASE_REG_LD = 1; BASE_REG_DATA = 8'hAA; ERR_CLR = 0;
    tick();
    idle();
    #1;
    expect_val("mrst_sp", K_SP, 8'd0);
    expect_val("mrst_base", K_BASE, 8'h00);
    expect_val("mrst_ovf", K_OVF, 8'd0);
    expect_val("mrst_unf", K_UNF, 8'd0);
    expect_val("mrst_empty", K_EMPTY, 8'd1);
    check_all();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_jmp_unit.md
CPU_JMP_UNIT -- requirements
Module: cpu_jmp_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the address and data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving return-stack entries; legal values are powers of two, at least 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: CLK (input, 1 bit, rising-edge clock) and RST (input, 1 bit, synchronous active-high reset).
REQ-004 EN  input  1  jump strobe; the mode is acted on only when EN=1.
REQ-005 JMP_MODE  input  3  mode select:
- 000 absolute; 001 base-relative; 010 PC-relative;
- 011 CALL absolute; 100 CALL base-relative; 101 RET;
- 110 and 111 are no-op.
REQ-006 OFFSET  input  WIDTH  jump operand: absolute target or offset.
REQ-007 PC_NEXT  input  WIDTH  sequential next PC; this is the fall-through address and the CALL return address.
REQ-008 BASE_REG_LD  input  1  base-register load strobe.
REQ-009 BASE_REG_DATA  input  WIDTH  base-register load value.
REQ-010 ERR_CLR  input  1  clears the sticky error flags.
REQ-011 ADDRESS_OUT  output  WIDTH  next-PC address (combinational).
REQ-012 JMP_TAKEN  output  1  high when ADDRESS_OUT is a jump target rather than PC_NEXT.
REQ-013 BASE_ADDR_OUT  output  WIDTH  current base register.
REQ-014 SP_OUT  output  clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
REQ-015 FULL, EMPTY  output  1 each  SP_OUT==DEPTH and SP_OUT==0 respectively.
REQ-016 OVF, UNF  output  1 each  sticky stack overflow and underflow flags.

Function
REQ-017 ADDRESS_OUT and JMP_TAKEN SHALL be combinational from inputs and registered state, with zero-cycle latency; the state update takes effect at the next CLK edge.
REQ-018 Target computation SHALL be:
- absolute = OFFSET; base-relative = BASE+OFFSET; PC-relative = PC_NEXT+OFFSET;
- all sums are modulo 2^WIDTH, and carry is discarded.
REQ-019 CALL modes SHALL form the target as their absolute or base-relative counterpart, and SHALL push PC_NEXT to stack[SP] and increment SP at the edge.
REQ-020 RET SHALL drive ADDRESS_OUT = stack[SP-1] combinationally and decrement SP at the edge.
REQ-021 When EN=0, or for a no-op mode, ADDRESS_OUT SHALL be PC_NEXT, JMP_TAKEN SHALL be 0, and the stack SHALL be unchanged.
REQ-022 CALL when FULL:
- the jump is still taken (JMP_TAKEN=1, target per REQ-019);
- no push occurs and SP is unchanged;
- OVF is set at the edge.
REQ-023 RET when EMPTY:
- ADDRESS_OUT = PC_NEXT and JMP_TAKEN = 0;
- SP is unchanged and UNF is set at the edge.
REQ-024 BASE_REG_LD=1 SHALL load BASE_REG_DATA into the base register at the edge, independent of EN.
REQ-025 When a base load and a base-relative jump occur in the same cycle, the jump SHALL use the old base.
REQ-026 ERR_CLR=1 SHALL clear OVF and UNF at the edge; if a new error occurs in the same cycle, the set wins.
REQ-027 A push followed by a pop SHALL return values in LIFO order, and the stack SHALL neither wrap nor overwrite valid entries.
REQ-028 The stack pointer SHALL be the only state sequencing stack storage; the block has no multi-cycle operations and no other FSM.

Reset
REQ-029 When RST=1 at an edge, the block SHALL set base=0, SP=0, OVF=0 and UNF=0, giving EMPTY=1, FULL=0 and BASE_ADDR_OUT=0.
REQ-030 RST SHALL dominate EN, BASE_REG_LD and ERR_CLR in the same cycle.
REQ-031 Stack storage contents SHALL NOT require reset; entries are unreadable until pushed.
REQ-032 During and after reset, ADDRESS_OUT SHALL follow REQ-021, or REQ-023 for RET.

Verification
REQ-033 Mode sweep, WIDTH=8, base=0x40, PC_NEXT=0x10, OFFSET=0x05, EN=1 -> expected ADDRESS_OUT per mode:
- 000 -> 0x05; 001 -> 0x45; 010 -> 0x15; 110 -> 0x10, JMP_TAKEN=0.
REQ-034 Wrap-around: base=0xF0, OFFSET=0x20, mode 001 -> ADDRESS_OUT=0x10, and no flag is set.
REQ-035 Call/return depth (DEPTH=4):
- 4 CALLs with PC_NEXT=0x11/0x22/0x33/0x44 -> SP=4, FULL=1;
- a 5th CALL -> target still taken, OVF=1, SP=4;
- 4 RETs -> 0x44, 0x33, 0x22, 0x11.
REQ-036 Underflow: RET at SP=0 with PC_NEXT=0x30 -> ADDRESS_OUT=0x30, JMP_TAKEN=0, UNF=1 next cycle.
- ERR_CLR then clears UNF.
- ERR_CLR coincident with a second RET -> UNF stays 1.
REQ-037 Base-load collision: base=0x10 with BASE_REG_LD=1 (DATA=0x80), same cycle mode 001 with OFFSET=0x01 -> ADDRESS_OUT=0x11; the next cycle gives 0x81.
REQ-038 Reset mid-operation: SP=3, base=0x55, OVF=1, assert RST together with a CALL -> next cycle SP=0, base=0, OVF=0, EMPTY=1.
